// File: rtl/opc_cpu_param_pkg.sv
// Shared types for the parametrised OPC accumulator core: FSM states, opcode
// encodings with the ALU group masks, and the link-register width helper.
package opc_cpu_param_pkg;

    typedef enum logic [2:0] {
        ST_FETCH0,
        ST_FETCH1,
        ST_RDMEM,
        ST_RDMEM2,
        ST_EXEC,
        ST_HALT
    } state_t;

    // Bit 4 of an ALU opcode selects direct (1) or immediate (0) operand.
    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_LDA  = 5'b00001;
    localparam logic [4:0] OP_NOT  = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_STAP = 5'b01000;
    localparam logic [4:0] OP_LDAP = 5'b01001;
    localparam logic [4:0] OP_STA  = 5'b11000;
    localparam logic [4:0] OP_JPC  = 5'b11001;
    localparam logic [4:0] OP_JPZ  = 5'b11010;
    localparam logic [4:0] OP_JP   = 5'b11011;
    localparam logic [4:0] OP_JSR  = 5'b11100;
    localparam logic [4:0] OP_RTS  = 5'b11101;
    localparam logic [4:0] OP_LXA  = 5'b11110;
    localparam logic [4:0] OP_HALT = 5'b11111;

    // x0xxx is the ALU group; 10xxx is its direct-operand half.
    localparam logic [4:0] OP_ALU_MASK  = 5'b01000;
    localparam logic [4:0] OP_ALU_MATCH = 5'b00000;
    localparam logic [4:0] OP_DIR_MASK  = 5'b11000;
    localparam logic [4:0] OP_DIR_MATCH = 5'b10000;
    localparam logic [4:0] OP_X_MASK    = 5'b01111;

    function automatic int link_width(input int data_w, input int addr_w);
        return addr_w - data_w;
    endfunction

endpackage

// File: rtl/opc_cpu_param_alu.sv
// Combinational next {C,ACC} for the ALU group and LDAP; other opcodes pass through.
// Zero latency, no handshake.
module opc_cpu_param_alu
    import opc_cpu_param_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [4:0]        opcode,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] op,
    input  logic              c,
    output logic [DATA_W-1:0] acc_nxt,
    output logic              c_nxt
);

    logic [DATA_W:0] sum;

    always_comb begin
        acc_nxt = acc;
        c_nxt   = c;
        sum     = '0;
        if ((opcode & OP_ALU_MASK) == OP_ALU_MATCH) begin
            case (opcode & OP_X_MASK)
                OP_AND: begin
                    acc_nxt = acc & op;
                    c_nxt   = 1'b0;
                end
                OP_LDA: acc_nxt = op;
                OP_NOT: acc_nxt = ~op;
                OP_ADD: begin
                    sum              = {1'b0, acc} + {1'b0, op} + {{DATA_W{1'b0}}, c};
                    {c_nxt, acc_nxt} = sum;
                end
                OP_OR: begin
                    acc_nxt = acc | op;
                    c_nxt   = 1'b0;
                end
                OP_XOR: begin
                    acc_nxt = acc ^ op;
                    c_nxt   = 1'b0;
                end
                // Carry in acts as not-borrow, so chained SUBs start with C=1.
                OP_SUB: begin
                    sum              = {1'b0, acc} + {1'b0, ~op} + {{DATA_W{1'b0}}, c};
                    {c_nxt, acc_nxt} = sum;
                end
                OP_ROR: {acc_nxt, c_nxt} = {c, acc};
                default: ;
            endcase
        end else if (opcode == OP_LDAP) begin
            acc_nxt = op;
        end
    end

endmodule

// File: rtl/opc_cpu_param.sv
// Parametrised two-word accumulator CPU; HALT instruction built in with OPC_HALT_EN.
// 2-4 bus cycles plus one EXEC cycle per instruction; every bus cycle (and
// write-EXEC) stalls while mem_ready=0, non-writing EXEC never waits.
module opc_cpu_param
    import opc_cpu_param_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 11,
    parameter logic [ADDR_W-1:0] RESET_PC = 'h100
) (
    input  logic              clk,
    input  logic              reset_b,
    output logic [ADDR_W-1:0] address,
    output logic              rnw,
    inout  wire  [DATA_W-1:0] data,
    input  logic              mem_ready,
    output logic              halted
);

    localparam int LW = link_width(DATA_W, ADDR_W);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                c_q, c_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [LW-1:0]       link_q, link_d;
    logic [4:0]          ir_q, ir_d;
    logic [ADDR_W-1:0]   or_q, or_d;

    logic [DATA_W-1:0]   alu_acc;
    logic                alu_c;
    logic                write_exec;
    logic                bus_state;
    logic                stall;
    logic                needs_rd;
    logic                drive_bus;

    opc_cpu_param_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode  (ir_q),
        .acc     (acc_q),
        .op      (or_q[DATA_W-1:0]),
        .c       (c_q),
        .acc_nxt (alu_acc),
        .c_nxt   (alu_c)
    );

    assign write_exec = (state_q == ST_EXEC) && ((ir_q == OP_STA) || (ir_q == OP_STAP));
    assign bus_state  = (state_q == ST_FETCH0) || (state_q == ST_FETCH1) ||
                        (state_q == ST_RDMEM)  || (state_q == ST_RDMEM2);
    assign stall      = !mem_ready && (bus_state || write_exec);
    // Direct ALU ops fetch their operand; pointer ops fetch the pointer.
    assign needs_rd   = ((ir_q & OP_DIR_MASK) == OP_DIR_MATCH) ||
                        (ir_q == OP_STAP) || (ir_q == OP_LDAP);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        c_d     = c_q;
        acc_d   = acc_q;
        link_d  = link_q;
        ir_d    = ir_q;
        or_d    = or_q;
        if (!stall) begin
            case (state_q)
                ST_FETCH0: begin
                    ir_d                   = data[DATA_W-1 -: 5];
                    or_d[ADDR_W-1 -: LW]   = data[DATA_W-6 -: LW];
                    pc_d                   = pc_q + ADDR_W'(1);
                    state_d                = ST_FETCH1;
                end
                ST_FETCH1: begin
                    or_d[DATA_W-1:0] = data;
                    pc_d             = pc_q + ADDR_W'(1);
                    state_d          = needs_rd ? ST_RDMEM : ST_EXEC;
                end
                ST_RDMEM: begin
                    or_d    = {{LW{1'b0}}, data};
                    state_d = (ir_q == OP_LDAP) ? ST_RDMEM2 : ST_EXEC;
                end
                ST_RDMEM2: begin
                    or_d[DATA_W-1:0] = data;
                    state_d          = ST_EXEC;
                end
                ST_EXEC: begin
                    state_d = ST_FETCH0;
                    acc_d   = alu_acc;
                    c_d     = alu_c;
                    case (ir_q)
                        OP_JPC: if (c_q) pc_d = or_q;
                        OP_JPZ: if (acc_q == '0) pc_d = or_q;
                        OP_JP:  pc_d = or_q;
                        OP_JSR: begin
                            {link_d, acc_d} = pc_q;
                            pc_d            = or_q;
                        end
                        OP_RTS: pc_d = {link_q, acc_q};
                        OP_LXA: begin
                            link_d          = acc_q[LW-1:0];
                            acc_d           = '0;
                            acc_d[LW-1:0]   = link_q;
                        end
`ifdef OPC_HALT_EN
                        OP_HALT: state_d = ST_HALT;
`endif
                        default: ;
                    endcase
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_FETCH0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_FETCH0;
            pc_q    <= RESET_PC;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            c_q     <= c_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q  <= acc_d;
        link_q <= link_d;
        ir_q   <= ir_d;
        or_q   <= or_d;
    end

    always_comb begin
        address = pc_q;
        if ((state_q == ST_RDMEM) || (state_q == ST_RDMEM2) || write_exec) begin
            address = or_q;
        end
    end

    // Reset gates the write strobe directly so an interrupted store cannot corrupt RAM.
    assign drive_bus = write_exec && reset_b;
    assign rnw       = ~drive_bus;
    assign data      = drive_bus ? acc_q : {DATA_W{1'bz}};

`ifdef OPC_HALT_EN
    assign halted = (state_q == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
